// File: rtl/dmux_router.sv
`default_nettype none
// ============================================================================
// Module      : dmux_router
// Description : Registered valid/ready demultiplexer. Routes one WIDTH-bit
//               input word to one of CHANNELS output streams chosen by
//               in_sel. Each channel has a one-entry holding register, so a
//               stalled consumer only blocks words addressed to it. Words
//               addressed past the last channel are dropped and counted in
//               a saturating 8-bit counter.
//               Optional feature macro: DMUX_ROUTER_BCAST_EN (broadcast of
//               one input word to every channel when in_bcast is high).
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_router #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [7:0]                drop_count
);

  localparam logic [SEL_W:0] C_CHANNELS = (SEL_W+1)'(CHANNELS);

  logic [CHANNELS-1:0]       full_q, full_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic [7:0]                drop_q, drop_d;

  logic [CHANNELS-1:0] w_avail;   // channel can take a word this cycle
  logic [CHANNELS-1:0] w_hit;     // one-hot decode of in_sel
  logic [CHANNELS-1:0] w_load;    // channel loads in_data at this edge
  logic [SEL_W:0]      w_sel_ext; // one spare bit so the range test is never constant
  logic                w_in_range;
  logic                w_bcast;
  logic                w_xfer;
  logic                w_drop;

`ifdef DMUX_ROUTER_BCAST_EN
  assign w_bcast = in_bcast;
`else
  // Broadcast is not built; the pin stays for a fixed pin list.
  logic w_unused_bcast;
  assign w_unused_bcast = in_bcast;
  assign w_bcast        = 1'b0;
`endif

  assign w_sel_ext  = {1'b0, in_sel};
  assign w_in_range = (w_sel_ext < C_CHANNELS);

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      // A channel is free if empty or if its word drains in this same cycle.
      assign w_avail[k] = !full_q[k] || out_ready[k];
      assign w_hit[k]   = (w_sel_ext == (SEL_W+1)'(k));
    end
  endgenerate

  // Broadcast needs every channel free; an out-of-range select is always
  // accepted because the word is simply discarded.
  assign in_ready = w_bcast    ? (&w_avail) :
                    w_in_range ? (|(w_hit & w_avail)) : 1'b1;

  assign w_xfer = in_valid && in_ready;
  assign w_load = w_bcast ? {CHANNELS{w_xfer}} : (w_hit & {CHANNELS{w_xfer}});
  assign w_drop = w_xfer && !w_bcast && !w_in_range;

  // Next-state: load wins over drain, drain alone clears full but keeps data.
  always_comb begin
    full_d = (full_q & ~out_ready) | w_load;
    data_d = data_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_load[k]) begin
        data_d[k*WIDTH +: WIDTH] = in_data;
      end
    end
    drop_d = drop_q;
    if (w_drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State registers; reset discards every held word and clears the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

  assign out_valid  = full_q;
  assign out_data   = data_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_dmux_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux_router
// Description : Directed self-checking bench for dmux_router. Instance u_dut
//               uses 8 channels; u_dut6 uses 6 channels to exercise drops.
//               Broadcast expectations follow DMUX_ROUTER_BCAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux_router;

  logic         clk;
  logic         reset;

  logic         iv, ir, ib;
  logic [15:0]  id;
  logic [2:0]   is;
  logic [7:0]   ov, ordy;
  logic [127:0] od;
  logic [7:0]   dc;

  logic         iv6, ir6, ib6;
  logic [15:0]  id6;
  logic [2:0]   is6;
  logic [5:0]   ov6, ordy6;
  logic [95:0]  od6;
  logic [7:0]   dc6;

  int n_vec = 0;
  int n_err = 0;

  dmux_router #(.WIDTH(16), .CHANNELS(8)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(iv), .in_ready(ir), .in_data(id), .in_sel(is), .in_bcast(ib),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .drop_count(dc)
  );

  dmux_router #(.WIDTH(16), .CHANNELS(6)) u_dut6 (
    .clk(clk), .reset(reset),
    .in_valid(iv6), .in_ready(ir6), .in_data(id6), .in_sel(is6), .in_bcast(ib6),
    .out_valid(ov6), .out_ready(ordy6), .out_data(od6), .drop_count(dc6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ch(input logic [127:0] d, input int k);
    return d[k*16 +: 16];
  endfunction

  initial begin
    reset = 1'b1;
    iv = 1'b0; ib = 1'b0; id = '0; is = '0; ordy = '0;
    iv6 = 1'b0; ib6 = 1'b0; id6 = '0; is6 = '0; ordy6 = '0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset / idle state
    chk("rst_ov", ov, 8'h00);
    chk("rst_od", od, 128'h0);
    chk("rst_dc", dc, 8'h00);
    for (int s = 0; s < 8; s++) begin
      is = 3'(s);
      #1;
      chk("idle_ready", ir, 1'b1);
    end

    // Word to channel 3 with every consumer stalled
    iv = 1'b1; id = 16'h00A5; is = 3'd3;
    #1 chk("c3_ready", ir, 1'b1);
    step();
    chk("c3_ov", ov, 8'h08);
    chk("c3_data", ch(od, 3), 16'h00A5);
    id = 16'h1111;
    #1 chk("c3_block", ir, 1'b0);
    step();
    chk("c3_hold_ov", ov, 8'h08);
    chk("c3_hold_data", ch(od, 3), 16'h00A5);
    id = 16'h0055; is = 3'd5;
    #1 chk("c5_ready", ir, 1'b1);
    step();
    chk("c5_ov", ov, 8'h28);
    chk("c5_data", ch(od, 5), 16'h0055);

    // Channel 2: fill, then drain and load on the same edge, then stream
    id = 16'h0002; is = 3'd2;
    step();
    chk("c2_fill_ov", ov, 8'h2C);
    ordy = 8'h04; id = 16'h1234;
    #1 chk("c2_pass_ready", ir, 1'b1);
    step();
    chk("c2_pass_ov", ov, 8'h2C);
    chk("c2_pass_data", ch(od, 2), 16'h1234);
    for (int i = 0; i < 4; i++) begin
      id = 16'h2000 + 16'(i);
      #1 chk("stream_ready", ir, 1'b1);
      step();
      chk("stream_data", ch(od, 2), 16'h2000 + 16'(i));
      chk("stream_ov", ov, 8'h2C);
    end

    // Drain everything; data registers keep their last word
    iv = 1'b0; ordy = 8'hFF;
    step();
    chk("drain_ov", ov, 8'h00);
    chk("drain_keep", ch(od, 3), 16'h00A5);
    chk("drain_dc", dc, 8'h00);

    // Broadcast with channel 0 full and stalled
    ordy = 8'h00; iv = 1'b1; ib = 1'b0; is = 3'd0; id = 16'h0C0C;
    step();
    chk("b_fill_ov", ov, 8'h01);
    ib = 1'b1; id = 16'hBEEF; is = 3'd6;
`ifdef DMUX_ROUTER_BCAST_EN
    #1 chk("b_block", ir, 1'b0);
    step();
    chk("b_block_ov", ov, 8'h01);
    ordy = 8'h01;
    #1 chk("b_ready", ir, 1'b1);
    step();
    chk("b_ov", ov, 8'hFF);
    chk("b_data", od, {8{16'hBEEF}});
`else
    #1 chk("nb_ready", ir, 1'b1);
    step();
    chk("nb_ov", ov, 8'h41);
    chk("nb_c6", ch(od, 6), 16'hBEEF);
    chk("nb_c0", ch(od, 0), 16'h0C0C);
`endif
    ib = 1'b0; iv = 1'b0; ordy = 8'hFF;
    step();
    chk("b_clear_ov", ov, 8'h00);

    // Reset while channels 1 and 4 are full and a transfer is offered
    ordy = 8'h00; iv = 1'b1; id = 16'h0101; is = 3'd1;
    step();
    id = 16'h0404; is = 3'd4;
    step();
    chk("pre_rst_ov", ov, 8'h12);
    id = 16'h7777; is = 3'd7;
    reset = 1'b1;
    step();
    chk("mid_rst_ov", ov, 8'h00);
    chk("mid_rst_od", od, 128'h0);
    chk("mid_rst_dc", dc, 8'h00);
    reset = 1'b0; iv = 1'b0;
    step();
    chk("post_rst_ov", ov, 8'h00);
    chk("post_rst_od", od, 128'h0);

    // Six-channel instance: out-of-range selects are dropped and counted
    ordy6 = 6'h00; iv6 = 1'b1; id6 = 16'hDEAD;
    for (int i = 0; i < 300; i++) begin
      is6 = (i % 2 == 1) ? 3'd7 : 3'd6;
      #1 chk("drop_ready", ir6, 1'b1);
      step();
      if (i == 0)   chk("drop_dc_1", dc6, 8'd1);
      if (i == 253) chk("drop_dc_254", dc6, 8'd254);
      if (i == 254) chk("drop_dc_255", dc6, 8'd255);
      if (i == 255) chk("drop_dc_sat", dc6, 8'd255);
    end
    chk("drop_dc_end", dc6, 8'd255);
    chk("drop_ov", ov6, 6'h00);
    chk("drop_od", od6, 96'h0);
    is6 = 3'd5; id6 = 16'h5A5A;
    #1 chk("c6_in_ready", ir6, 1'b1);
    step();
    chk("c6_in_ov", ov6, 6'h20);
    chk("c6_in_data", od6[80 +: 16], 16'h5A5A);
    chk("c6_in_dc", dc6, 8'd255);
    iv6 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
